// File: rtl/score_uart_tx.sv
// Game-state telemetry: sends "S<5 hex>L<d>C<d>\r\n" over 8N1 UART whenever the
// watched state changes or a send is requested. Latency: tx falls one edge after a trigger.
module score_uart_tx #(
  parameter int CLK_DIV = 104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] score,
  input  logic [1:0]  lives,
  input  logic [1:0]  scene,
  input  logic        send_req,
  output logic        tx,
  output logic        busy
);

  localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [3:0]  byte_idx;
  logic [7:0]  shreg;
  logic [23:0] snap;
  logic [23:0] last_sent;
  logic        pending;

  logic [23:0] live;
  logic        trigger;

  assign live    = {score, lives, scene};
  assign trigger = pending | send_req | (live != last_sent);

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte idx of the status line, formatted from a {score, lives, scene} snapshot.
  function automatic logic [7:0] line_byte(input logic [3:0] idx, input logic [23:0] s);
    case (idx)
      4'd0:    return 8'h53;
      4'd1:    return hex_ascii(s[23:20]);
      4'd2:    return hex_ascii(s[19:16]);
      4'd3:    return hex_ascii(s[15:12]);
      4'd4:    return hex_ascii(s[11:8]);
      4'd5:    return hex_ascii(s[7:4]);
      4'd6:    return 8'h4C;
      4'd7:    return 8'h30 + {6'h00, s[3:2]};
      4'd8:    return 8'h43;
      4'd9:    return 8'h30 + {6'h00, s[1:0]};
      4'd10:   return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      snap      <= '0;
      last_sent <= '0;
      pending   <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      // Any number of requests during a line collapse into a single follow-up line.
      if (send_req && busy) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (trigger) begin
            snap      <= live;
            last_sent <= live;
            byte_idx  <= '0;
            shreg     <= line_byte(4'd0, live);
            pending   <= 1'b0;
            busy      <= 1'b1;
            tx        <= 1'b0;
            baud_cnt  <= BAUD_MAX;
            state     <= START;
          end
        end
        START: begin
          if (baud_cnt == 16'd0) begin
            baud_cnt <= BAUD_MAX;
            tx       <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            bit_cnt  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (baud_cnt == 16'd0) begin
            baud_cnt <= BAUD_MAX;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (baud_cnt == 16'd0) begin
            if (byte_idx < 4'd11) begin
              byte_idx <= byte_idx + 4'd1;
              shreg    <= line_byte(byte_idx + 4'd1, snap);
              tx       <= 1'b0;
              baud_cnt <= BAUD_MAX;
              state    <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_uart_tx.sv
// Scoreboard bench for score_uart_tx at CLK_DIV=4: a UART decoder pops expected
// bytes as lines are received; the main thread checks timing around each line.
module tb_score_uart_tx;

  localparam int DIV = 4;
  localparam int LINE_CYC = 120 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] score = '0;
  logic [1:0]  lives = '0;
  logic [1:0]  scene = '0;
  logic        send_req = 1'b0;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  score_uart_tx #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .score(score), .lives(lives), .scene(scene),
    .send_req(send_req), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n > 4'd9) return 8'd55 + 8'(n);
    return 8'd48 + 8'(n);
  endfunction

  task automatic push_line(input logic [19:0] s, input logic [1:0] l, input logic [1:0] c);
    exp_q.push_back(8'h53);
    for (int i = 4; i >= 0; i--) exp_q.push_back(hexc(s[i*4 +: 4]));
    exp_q.push_back(8'h4C);
    exp_q.push_back(8'h30 + 8'(l));
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h30 + 8'(c));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_literal(input logic [95:0] l);
    for (int i = 11; i >= 0; i--) exp_q.push_back(l[i*8 +: 8]);
  endtask

  task automatic wait_rise(input int limit);
    int n = 0;
    while (busy !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic line_len(output int len);
    len = 0;
    while (busy === 1'b1 && len < 2000) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic gap_len(output int gap);
    gap = 0;
    while (busy !== 1'b1 && gap < 2000) begin
      gap++;
      @(negedge clk);
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  task automatic pulse_req();
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
  endtask

  // UART receiver: samples every cycle of each bit so a wrong bit width is caught.
  initial begin
    logic [9:0] bits;
    logic       bad;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        aborted = 1'b0;
        bad = 1'b0;
        bits = '0;
        for (int c = 0; c < 10 * DIV; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (c % DIV == 0) bits[c / DIV] = tx;
          else if (tx !== bits[c / DIV]) bad = 1'b1;
        end
        if (!aborted) begin
          check("bit_timing", 32'(bad), 32'd0);
          check("framing", 32'({bits[9], bits[0]}), 32'd2);
          if (exp_q.size() == 0) check("extra_byte", 32'd1, 32'd0);
          else check("byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int len;
    int gap;
    // Reset and idle with all-zero state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    quiet("idle_after_reset", 1000);

    // Single line with mixed digits
    push_literal(96'h53_31_41_32_42_33_4C_32_43_31_0D_0A);
    score = 20'h1A2B3; lives = 2'd2; scene = 2'd1;
    @(negedge clk);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_tx", 32'(tx), 32'd0);
    line_len(len);
    check("busy_len", 32'(len), 32'(LINE_CYC));
    check("q_empty1", 32'(exp_q.size()), 32'd0);
    quiet("idle1", 50);

    // Mid-line change during byte 3
    push_line(20'h1A2B3, 2'd2, 2'd1);
    pulse_req();
    wait_rise(5);
    repeat (130) @(negedge clk);
    score = 20'h00001;
    push_line(20'h00001, 2'd2, 2'd1);
    line_len(len);
    gap_len(gap);
    check("retrigger_gap", 32'(gap), 32'd1);
    line_len(len);
    check("busy_len2", 32'(len), 32'(LINE_CYC));
    check("q_empty2", 32'(exp_q.size()), 32'd0);
    quiet("idle2", 50);

    // Three requests in one line collapse to one duplicate
    push_line(20'h00001, 2'd2, 2'd1);
    push_line(20'h00001, 2'd2, 2'd1);
    pulse_req();
    wait_rise(5);
    repeat (50) @(negedge clk);
    pulse_req();
    repeat (150) @(negedge clk);
    pulse_req();
    repeat (150) @(negedge clk);
    pulse_req();
    line_len(len);
    gap_len(gap);
    check("dup_gap", 32'(gap), 32'd1);
    line_len(len);
    check("dup_len", 32'(len), 32'(LINE_CYC));
    quiet("no_third_line", 600);
    check("q_empty3", 32'(exp_q.size()), 32'd0);

    // Request coinciding with a value change gives one line
    push_line(20'h00002, 2'd2, 2'd1);
    score = 20'h00002;
    pulse_req();
    line_len(len);
    check("combo_len", 32'(len), 32'(LINE_CYC));
    quiet("combo_single", 300);

    // Request on the exact edge busy falls
    push_line(20'h00002, 2'd2, 2'd1);
    push_line(20'h00002, 2'd2, 2'd1);
    pulse_req();
    wait_rise(5);
    repeat (LINE_CYC - 1) @(negedge clk);
    check("pre_fall_busy", 32'(busy), 32'd1);
    pulse_req();
    check("fall_busy", 32'(busy), 32'd0);
    gap_len(gap);
    check("edge_req_gap", 32'(gap), 32'd1);
    line_len(len);
    check("edge_req_len", 32'(len), 32'(LINE_CYC));
    quiet("edge_req_idle", 300);

    // Full hex range
    push_literal(96'h53_46_46_46_46_46_4C_33_43_33_0D_0A);
    score = 20'hFFFFF; lives = 2'd3; scene = 2'd3;
    @(negedge clk);
    line_len(len);
    check("hex_len", 32'(len), 32'(LINE_CYC));
    check("q_empty4", 32'(exp_q.size()), 32'd0);
    quiet("idle4", 50);

    // Reset during byte 5, then a fresh line on release
    push_line(20'h12345, 2'd1, 2'd2);
    score = 20'h12345; lives = 2'd1; scene = 2'd2;
    wait_rise(5);
    repeat (210) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_line(20'h12345, 2'd1, 2'd2);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd1);
    line_len(len);
    check("post_rst_len", 32'(len), 32'(LINE_CYC));
    quiet("final_idle", 100);
    check("q_empty_final", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_uart_tx.md
# score_uart_tx

Serial telemetry stage that drives the board's `tx` pin, which is otherwise held idle. It watches the game-state outputs of the main game FSM (score, lives, scene) and transmits an ASCII status line over 8N1 UART. A line is sent whenever any watched value differs from the last one transmitted, or when a send is requested explicitly. It sits directly downstream of the game FSM and in parallel with the on-screen score and heart displays.

## Interface
Parameters:
- `CLK_DIV`, default 104: clock cycles per UART bit. 104 at 12 MHz gives about 115200 baud. Legal range is 2..65535.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: asynchronous, active-high reset.
- `score`  in  20: current score, binary.
- `lives`  in  2: remaining lives, 0..3.
- `scene`  in  2: current scene code.
- `send_req`  in  1: single-cycle request to send a line even if nothing changed.
- `tx`  out  1: UART serial output; idles high.
- `busy`  out  1: high while a line is being transmitted.

## Operation
- Line format is 12 bytes, sent in this order:
  - `'S'` (0x53)
  - 5 hex digits of `score`, most significant nibble first
  - `'L'` (0x4C), then the `lives` digit
  - `'C'` (0x43), then the `scene` digit
  - CR (0x0D), LF (0x0A)
- Hex-to-ASCII mapping:
  - nibble 0..9 → 0x30..0x39
  - nibble A..F → 0x41..0x46 (uppercase)
  - `lives` and `scene` → 0x30..0x33
- Snapshot:
  - `{score, lives, scene}` is captured into a 24-bit snapshot register when a line starts.
  - All 12 bytes are formatted from the snapshot, never from the live inputs.
  - `last_sent` is loaded with the snapshot at the same edge.
- Trigger, evaluated only in IDLE: start a line if `pending` is set, `send_req` is high, or the live `{score, lives, scene}` differs from `last_sent`.
- `pending` flag:
  - Set by `send_req` when it arrives while `busy` is high.
  - Cleared when the next line starts.
  - Multiple requests during one line collapse into one extra line.
- Input changes during a line do not alter that line. After the line completes, the inequality with `last_sent` re-triggers a new line.
- State machine:
  - IDLE → START on a trigger: snapshot taken, byte index set to 0, byte 0 loaded into the shift register.
  - START drives `tx`=0 for `CLK_DIV` cycles → DATA.
  - DATA shifts 8 bits out, LSB first, `CLK_DIV` cycles each → STOP.
  - STOP drives `tx`=1 for `CLK_DIV` cycles. Then:
    - if byte index < 11: increment the index, load the next byte, go to START;
    - else go to IDLE.
- Bytes are sent back-to-back with no gap beyond the single stop bit.
- Arithmetic:
  - Baud counter is 16 bits and counts `CLK_DIV-1` down to 0.
  - Bit counter is 3 bits; byte index is 4 bits.
  - Counters never wrap in normal operation; the index is compared against 11.
- Reset state: `last_sent` = 0. Consequently, any nonzero game state after reset produces a line immediately.

## Timing
- Reset values:
  - `tx`=1, `busy`=0
  - state IDLE, `pending`=0
  - `last_sent`=0, snapshot=0
- Latency: if a trigger is sampled at edge k:
  - `tx` falls after edge k and `busy` rises after edge k (same edge).
- Every bit lasts exactly `CLK_DIV` cycles. One byte takes 10×`CLK_DIV` cycles; one line takes 120×`CLK_DIV` cycles.
- `busy` falls at the edge ending the last stop bit. The earliest next start is at that same edge's next trigger evaluation, i.e. 1 cycle later. The minimum idle `tx`-high time between lines is `CLK_DIV`+1 cycles.
- `send_req` in the same cycle as a value change starts one line only, not two.
- `send_req` on the exact cycle `busy` falls sets `pending`; the result is one additional line.
- Reset asserted mid-line:
  - `tx` goes to 1 and `busy` to 0 asynchronously.
  - The partial line is abandoned, with no completion.
- After reset release: a line starts on the first clock edge if the inputs are nonzero.

## Test plan
- Reset: hold `rst`, then release with `score`=0, `lives`=0, `scene`=0 → `tx`=1 and `busy`=0 throughout, no line for 1000 cycles.
- Single line, `CLK_DIV`=4:
  - Stimulus: `score`=0x1A2B3, `lives`=2, `scene`=1.
  - Decoded bytes must be 53 31 41 32 42 33 4C 32 43 31 0D 0A.
  - Each bit lasts 4 cycles; `busy` stays high for exactly 480 cycles.
- Mid-line change:
  - Stimulus: during byte 3, change `score` to 0x00001.
  - Current line is unchanged.
  - A second line "S00001L2C1\r\n" starts 1 cycle after `busy` falls.
- Explicit request: inputs steady, three `send_req` pulses during one line → exactly one duplicate line follows; then idle.
- Reset mid-line:
  - Stimulus: assert `rst` during byte 5.
  - `tx`=1 and `busy`=0 in the same cycle.
  - On release with nonzero inputs, a full fresh line starts with byte 0x53.
- Hex range: `score`=0xFFFFF, `lives`=3, `scene`=3 → bytes 53 46 46 46 46 46 4C 33 43 33 0D 0A.
